wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master, one-slave Wishbone arbiter that lets the instruction-fetch master and the load/store master share one memory port. It sits between the fetch state machine's `WB4` master port, the data-access unit's `WB4` master port, and the single memory/interconnect `WB4` slave. Grants are round-robin and held for the whole cycle (`CYC` high). A watchdog terminates transactions the slave never acknowledges, so a bad address cannot hang the core.

## Interface
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `ACK` before forced termination; counter width is `$clog2(TIMEOUT+1)`.
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `inst_bus`  WB4.slave  —  fetch master: `CYC`, `STB`, `WE`, `ADR[31:0]`, `DAT_O[31:0]` in; `DAT_I[31:0]`, `ACK` out.
- `data_bus`  WB4.slave  —  load/store master; same signal set as `inst_bus`.
- `mem_bus`  WB4.master  —  shared slave port: `CYC`, `STB`, `WE`, `ADR`, `DAT_O` out; `DAT_I`, `ACK` in.
- `grant`  output  2  one-hot current owner: `[0]` is inst, `[1]` is data; `2'b00` when idle.
- `bus_timeout`  output  1  sticky flag, set on any watchdog expiry; cleared only by reset.

## Operation
- Request: a master is requesting when its `CYC & STB` are both high.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only inst requesting: go to GNT_I.
  - Only data requesting: go to GNT_D.
  - Both requesting: grant the master that did *not* own the most recent grant. The `last` register resets to inst, so data wins the first tie.
  - No request: stay in IDLE.
- GNT_x:
  - `mem_bus` outputs mirror master x combinationally.
  - `mem_bus.DAT_I` and `mem_bus.ACK` are routed to master x only.
  - The non-granted master sees `ACK=0` and `DAT_I=0`.
  - Return to IDLE on the first cycle where master x has `CYC=0`.
  - Set `last` to x on entering GNT_x.
- IDLE outputs: `mem_bus` `CYC`, `STB`, `WE` are 0; `ADR` and `DAT_O` are 0. Both masters see `ACK=0`.
- Watchdog:
  - The counter clears on entering GNT_x and on every cycle with `mem_bus.ACK=1`.
  - It increments each GNT cycle with `STB=1` and `ACK=0`.
  - When the count reaches `TIMEOUT`, the arbiter does all of the following in that cycle:
    - drives a one-cycle `ACK=1` with `DAT_I=32'h0000_0000` to master x;
    - forces `mem_bus.CYC` and `mem_bus.STB` to 0;
    - sets `bus_timeout`;
    - goes to IDLE next cycle.
- Handover always passes through IDLE, so there is one dead cycle between owners. No master is ever preempted mid-cycle.
- Back-to-back requests: if the owner re-raises `CYC` in the cycle right after it drops it, the arbiter treats this as a new request in IDLE, subject to round-robin.

## Timing
- Reset (`rst=0` at a clock edge):
  - state goes to IDLE, `grant=0`, `last`=inst, watchdog=0, `bus_timeout=0`;
  - all `mem_bus` outputs and both master `ACK`s are 0 from the next cycle.
  - Reset mid-transaction drops `mem_bus.CYC` immediately (next edge), with no ACK to the master.
- Grant latency: a request sampled in IDLE at edge n gives GNT_x from n+1. `mem_bus.CYC` is high in cycle n+1, one cycle after the request.
- ACK path is combinational: slave `ACK` in cycle k reaches the owner in cycle k.
- Release latency: owner `CYC` low in cycle k gives IDLE at k+1. A waiting master is granted at k+2.
- Watchdog terminal `ACK` fires in the cycle with count == `TIMEOUT`, which is `TIMEOUT`+1 cycles after `STB` rose with no ACK.
- Simultaneous `mem_bus.ACK` and timeout in the same cycle: treat as a normal ACK; no timeout flag, slave data passed through.

## Test plan
- Single fetch:
  - Stimulus: inst reads `ADR=0x100`, slave ACKs 2 cycles after `STB` with `0x00000013`.
  - Required: `grant=01` one cycle after the request; inst sees `DAT_I=0x13` with ACK; IDLE one cycle after inst drops `CYC`; data port ACK never asserted.
- Tie from reset:
  - Stimulus: both request in the same cycle.
  - Required: data granted first (`grant=10`), inst granted 2 cycles after data drops `CYC`; next simultaneous tie goes to data again only after an inst grant.
- Continuous fetch with data pending:
  - Stimulus: inst re-requests every cycle it is idle; data requests once.
  - Required: data granted at the first IDLE after the current inst cycle ends; inst is not starved over 100 alternating ties (grant counts differ by ≤1).
- Write passthrough:
  - Stimulus: data write `ADR=0x2000`, `DAT_O=0xCAFEBABE`, `WE=1`.
  - Required: `mem_bus` shows identical `ADR`, `DAT_O`, `WE` while `grant=10`; inst `ACK` stays 0.
- Timeout:
  - Stimulus: `TIMEOUT=4`, slave never ACKs an inst read.
  - Required: inst ACK with `DAT_I=0` exactly 5 cycles after `STB` rose; `bus_timeout=1` and stays set; a later data cycle completes normally.
- Mid-cycle reset:
  - Stimulus: assert `rst=0` during GNT_D before ACK.
  - Required: next cycle `mem_bus.CYC=0`, `grant=00`, `bus_timeout=0`, no ACK to data; after release, a tie grants data.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter. The fetch and load/store masters share
// one memory port: round-robin grants are held for the whole CYC, and a watchdog ends unacknowledged cycles.
module wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_cyc,
  input  logic        i_inst_stb,
  input  logic        i_inst_we,
  input  logic [31:0] i_inst_adr,
  input  logic [31:0] i_inst_dat,
  output logic [31:0] o_inst_dat,
  output logic        o_inst_ack,
  input  logic        i_data_cyc,
  input  logic        i_data_stb,
  input  logic        i_data_we,
  input  logic [31:0] i_data_adr,
  input  logic [31:0] i_data_dat,
  output logic [31:0] o_data_dat,
  output logic        o_data_ack,
  output logic        o_mem_cyc,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  output logic [1:0]  o_grant,
  output logic        o_bus_timeout,
  output logic [1:0]  o_state
);
  // Handshake: a master requests with CYC&STB high; a beat completes in the
  // cycle ACK is high, and the owner keeps the bus until it drops CYC.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [CW-1:0] r_wdog;
  logic          r_timeout;

  logic          w_inst_req;
  logic          w_data_req;
  logic          w_granted;
  logic          w_own_cyc;
  logic          w_own_stb;
  logic          w_own_we;
  logic [31:0]   w_own_adr;
  logic [31:0]   w_own_dat;
  logic          w_expire;

  assign w_inst_req = i_inst_cyc & i_inst_stb;
  assign w_data_req = i_data_cyc & i_data_stb;
  assign w_granted  = (r_state == GNT_I) || (r_state == GNT_D);

  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = 32'h0;
    w_own_dat = 32'h0;
    case (r_state)
      GNT_I: begin
        w_own_cyc = i_inst_cyc;
        w_own_stb = i_inst_stb;
        w_own_we  = i_inst_we;
        w_own_adr = i_inst_adr;
        w_own_dat = i_inst_dat;
      end
      GNT_D: begin
        w_own_cyc = i_data_cyc;
        w_own_stb = i_data_stb;
        w_own_we  = i_data_we;
        w_own_adr = i_data_adr;
        w_own_dat = i_data_dat;
      end
      default: ;
    endcase
  end

  // A slave ACK in the terminal cycle wins over the watchdog.
  assign w_expire = w_granted & w_own_cyc & w_own_stb & ~i_mem_ack & (r_wdog == TO_VAL);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_inst_req && w_data_req) begin
          // r_last: 0 = inst owned last, 1 = data owned last
          if (r_last) begin
            w_state_nxt = GNT_I;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = GNT_D;
            w_last_nxt  = 1'b1;
          end
        end else if (w_inst_req) begin
          w_state_nxt = GNT_I;
          w_last_nxt  = 1'b0;
        end else if (w_data_req) begin
          w_state_nxt = GNT_D;
          w_last_nxt  = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (!w_own_cyc || w_expire) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (!w_granted || i_mem_ack) begin
        r_wdog <= '0;
      end else if (w_own_stb && (r_wdog != TO_VAL)) begin
        r_wdog <= r_wdog + CW'(1);
      end
      if (w_expire) r_timeout <= 1'b1;
    end
  end

  assign o_mem_cyc = w_own_cyc & ~w_expire;
  assign o_mem_stb = w_own_stb & ~w_expire;
  assign o_mem_we  = w_own_we;
  assign o_mem_adr = w_own_adr;
  assign o_mem_dat = w_own_dat;

  assign o_inst_ack = (r_state == GNT_I) & (i_mem_ack | w_expire);
  assign o_inst_dat = ((r_state == GNT_I) && !w_expire) ? i_mem_dat : 32'h0;
  assign o_data_ack = (r_state == GNT_D) & (i_mem_ack | w_expire);
  assign o_data_dat = ((r_state == GNT_D) && !w_expire) ? i_mem_dat : 32'h0;

  assign o_grant       = {r_state == GNT_D, r_state == GNT_I};
  assign o_bus_timeout = r_timeout;
  assign o_state       = r_state;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenario tasks plus randomized traffic checked
// against a transaction-level model of the arbitration and watchdog rules.
module tb_wb_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_cyc, inst_stb, inst_we;
  logic [31:0] inst_adr, inst_wdat;
  logic        data_cyc, data_stb, data_we;
  logic [31:0] data_adr, data_wdat;
  logic        mem_ack;
  logic [31:0] mem_rdat;

  logic [31:0] o_inst_dat, o_data_dat, o_mem_adr, o_mem_dat;
  logic        o_inst_ack, o_data_ack, o_mem_cyc, o_mem_stb, o_mem_we, o_bus_timeout;
  logic [1:0]  o_grant, o_state;

  wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_cyc(inst_cyc), .i_inst_stb(inst_stb), .i_inst_we(inst_we),
    .i_inst_adr(inst_adr), .i_inst_dat(inst_wdat),
    .o_inst_dat(o_inst_dat), .o_inst_ack(o_inst_ack),
    .i_data_cyc(data_cyc), .i_data_stb(data_stb), .i_data_we(data_we),
    .i_data_adr(data_adr), .i_data_dat(data_wdat),
    .o_data_dat(o_data_dat), .o_data_ack(o_data_ack),
    .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
    .i_mem_dat(mem_rdat), .i_mem_ack(mem_ack),
    .o_grant(o_grant), .o_bus_timeout(o_bus_timeout), .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t required finish earlier", $time);
    $fatal(1, "bench time limit exceeded");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [135:0] v_got, v_exp;

  // ---------------- reference model ----------------
  // owner: 0 none, 1 inst, 2 data; last: most recent owner
  int   m_owner = 0;
  int   m_last  = 1;
  int   m_wait  = 0;
  logic m_flag  = 1'b0;

  logic [1:0]  e_grant;
  logic        e_mem_cyc, e_mem_stb, e_mem_we, e_inst_ack, e_data_ack, e_timeout, e_expire;
  logic [31:0] e_mem_adr, e_mem_dat, e_inst_dat, e_data_dat;

  task automatic settle();
    logic        oc, os, ow;
    logic [31:0] oa, od;
    #1;
    e_grant = 2'b00; e_mem_cyc = 0; e_mem_stb = 0; e_mem_we = 0;
    e_mem_adr = 0; e_mem_dat = 0; e_inst_ack = 0; e_inst_dat = 0;
    e_data_ack = 0; e_data_dat = 0; e_expire = 0;
    e_timeout = m_flag;
    oc = 0; os = 0; ow = 0; oa = 0; od = 0;
    if (m_owner == 1) begin
      oc = inst_cyc; os = inst_stb; ow = inst_we; oa = inst_adr; od = inst_wdat;
    end else if (m_owner == 2) begin
      oc = data_cyc; os = data_stb; ow = data_we; oa = data_adr; od = data_wdat;
    end
    if (m_owner != 0) begin
      e_expire  = (m_wait == TO) && oc && os && !mem_ack;
      e_mem_cyc = oc && !e_expire;
      e_mem_stb = os && !e_expire;
      e_mem_we  = ow;
      e_mem_adr = oa;
      e_mem_dat = od;
      if (m_owner == 1) begin
        e_grant = 2'b01;
        e_inst_ack = mem_ack || e_expire;
        e_inst_dat = e_expire ? 32'h0 : mem_rdat;
      end else begin
        e_grant = 2'b10;
        e_data_ack = mem_ack || e_expire;
        e_data_dat = e_expire ? 32'h0 : mem_rdat;
      end
    end
  endtask

  task automatic model_commit();
    logic ir, dr, oc, os;
    int   nxt;
    if (!rst) begin
      m_owner = 0; m_last = 1; m_wait = 0; m_flag = 0;
      return;
    end
    m_flag = m_flag | e_expire;
    ir = inst_cyc && inst_stb;
    dr = data_cyc && data_stb;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (ir && dr) nxt = (m_last == 1) ? 2 : 1;
      else if (ir)  nxt = 1;
      else if (dr)  nxt = 2;
      if (nxt != 0) begin
        m_last = nxt;
        m_wait = 0;
      end
    end else begin
      oc = (m_owner == 1) ? inst_cyc : data_cyc;
      os = (m_owner == 1) ? inst_stb : data_stb;
      if (!oc || e_expire) nxt = 0;
      else if (mem_ack)    m_wait = 0;
      else if (os)         m_wait = m_wait + 1;
    end
    m_owner = nxt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_inst(input logic c, input logic s, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    inst_cyc = c; inst_stb = s; inst_we = w; inst_adr = a; inst_wdat = d;
  endtask

  task automatic set_data(input logic c, input logic s, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    data_cyc = c; data_stb = s; data_we = w; data_adr = a; data_wdat = d;
  endtask

  task automatic set_slave(input logic a, input logic [31:0] d);
    mem_ack = a; mem_rdat = d;
  endtask

  task automatic drive_idle();
    set_inst(0, 0, 0, 0, 0);
    set_data(0, 0, 0, 0, 0);
    set_slave(0, 0);
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) begin
      settle();
      next_cycle();
    end
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    settle();
    next_cycle();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    settle();
    next_cycle();
    set_inst(1, 1, 0, 32'h100, 0);
    set_data(1, 1, 0, 32'h200, 0);
    settle();
    next_cycle();
    settle();
    n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", o_grant); end
    n_cmp++; if ({o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat} !== 67'h0) begin
      n_err++; $display("FAIL reset_mem_outputs: got %b%b%b %h %h want all zero", o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat);
    end
    n_cmp++; if ({o_inst_ack, o_data_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b want 00", {o_inst_ack, o_data_ack}); end
    n_cmp++; if (o_bus_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", o_bus_timeout); end
    rst = 1'b1;
    drive_idle();
    idle_cycles(1);
  endtask

  task automatic test_single_fetch();
    set_inst(1, 1, 0, 32'h100, 0);
    settle();
    n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL fetch_req_cycle_grant: got %b want 00", o_grant); end
    next_cycle();
    settle();
    n_cmp++; if (o_grant !== 2'b01) begin n_err++; $display("FAIL fetch_grant: got %b want 01", o_grant); end
    n_cmp++; if ({o_mem_cyc, o_mem_adr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL fetch_mem_adr: got %b %h want 1 00000100", o_mem_cyc, o_mem_adr); end
    next_cycle();
    set_slave(1, 32'h0000_0013);
    settle();
    n_cmp++; if ({o_inst_ack, o_inst_dat} !== {1'b1, 32'h13}) begin n_err++; $display("FAIL fetch_ack_data: got %b %h want 1 00000013", o_inst_ack, o_inst_dat); end
    n_cmp++; if (o_data_ack !== 1'b0) begin n_err++; $display("FAIL fetch_data_ack: got %b want 0", o_data_ack); end
    next_cycle();
    set_inst(0, 0, 0, 0, 0);
    set_slave(0, 0);
    settle();
    n_cmp++; if ({o_grant, o_mem_cyc} !== {2'b01, 1'b0}) begin n_err++; $display("FAIL fetch_drop: got %b %b want 01 0", o_grant, o_mem_cyc); end
    next_cycle();
    settle();
    n_cmp++; if ({o_grant, o_data_ack} !== 3'b000) begin n_err++; $display("FAIL fetch_release: got %b %b want 00 0", o_grant, o_data_ack); end
    next_cycle();
  endtask

  task automatic test_tie_from_reset();
    do_reset();
    set_inst(1, 1, 0, 32'h200, 0);
    set_data(1, 1, 0, 32'h300, 0);
    settle();
    next_cycle();
    set_slave(1, 32'hA1);
    settle();
    n_cmp++; if (o_grant !== 2'b10) begin n_err++; $display("FAIL tie_first_grant: got %b want 10", o_grant); end
    n_cmp++; if ({o_data_ack, o_data_dat, o_inst_ack, o_inst_dat} !== {1'b1, 32'hA1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL tie_ack_route: got %b %h %b %h want 1 000000a1 0 00000000", o_data_ack, o_data_dat, o_inst_ack, o_inst_dat);
    end
    next_cycle();
    set_data(0, 0, 0, 0, 0);
    set_slave(0, 0);
    settle();
    next_cycle();
    settle();
    n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL tie_dead_cycle: got %b want 00", o_grant); end
    next_cycle();
    set_slave(1, 32'hB2);
    settle();
    n_cmp++; if ({o_grant, o_inst_ack, o_inst_dat} !== {2'b01, 1'b1, 32'hB2}) begin
      n_err++; $display("FAIL tie_inst_second: got %b %b %h want 01 1 000000b2", o_grant, o_inst_ack, o_inst_dat);
    end
    next_cycle();
    set_inst(0, 0, 0, 0, 0);
    set_data(1, 1, 0, 32'h304, 0);
    set_slave(0, 0);
    settle();
    next_cycle();
    set_inst(1, 1, 0, 32'h204, 0);
    settle();
    next_cycle();
    set_slave(1, 32'hC3);
    settle();
    n_cmp++; if (o_grant !== 2'b10) begin n_err++; $display("FAIL tie_after_inst: got %b want 10", o_grant); end
    next_cycle();
    set_data(0, 0, 0, 0, 0);
    set_slave(0, 0);
    settle();
    next_cycle();
    settle();
    next_cycle();
    set_slave(1, 32'hD4);
    settle();
    n_cmp++; if (o_grant !== 2'b01) begin n_err++; $display("FAIL tie_after_data: got %b want 01", o_grant); end
    next_cycle();
    idle_cycles(2);
  endtask

  task automatic test_write_passthrough();
    set_data(1, 1, 1, 32'h2000, 32'hCAFE_BABE);
    settle();
    next_cycle();
    settle();
    n_cmp++; if ({o_grant, o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat} !== {2'b10, 3'b111, 32'h2000, 32'hCAFE_BABE}) begin
      n_err++; $display("FAIL write_pass: got %b %b%b%b %h %h want 10 111 00002000 cafebabe", o_grant, o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat);
    end
    next_cycle();
    set_slave(1, 32'h0);
    settle();
    n_cmp++; if ({o_data_ack, o_inst_ack} !== 2'b10) begin n_err++; $display("FAIL write_acks: got %b want 10", {o_data_ack, o_inst_ack}); end
    next_cycle();
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    do_reset();
    // slave ACK arriving exactly in the terminal cycle is a normal ACK
    set_inst(1, 1, 0, 32'h400, 0);
    settle();
    next_cycle();
    for (int i = 0; i < TO; i++) begin
      settle();
      next_cycle();
    end
    set_slave(1, 32'h77);
    settle();
    n_cmp++; if ({o_inst_ack, o_inst_dat, o_mem_cyc} !== {1'b1, 32'h77, 1'b1}) begin
      n_err++; $display("FAIL coincident_ack: got %b %h %b want 1 00000077 1", o_inst_ack, o_inst_dat, o_mem_cyc);
    end
    next_cycle();
    set_inst(0, 0, 0, 0, 0);
    set_slave(0, 0);
    settle();
    next_cycle();
    settle();
    n_cmp++; if (o_bus_timeout !== 1'b0) begin n_err++; $display("FAIL coincident_flag: got %b want 0", o_bus_timeout); end
    next_cycle();
    // slave never acknowledges
    set_inst(1, 1, 0, 32'h500, 0);
    set_slave(0, 32'hDEAD_BEEF);
    settle();
    next_cycle();
    for (int i = 0; i < TO; i++) begin
      settle();
      n_cmp++; if ({o_grant, o_inst_ack} !== 3'b010) begin n_err++; $display("FAIL timeout_wait_%0d: got %b %b want 01 0", i, o_grant, o_inst_ack); end
      next_cycle();
    end
    settle();
    n_cmp++; if ({o_inst_ack, o_inst_dat, o_mem_cyc, o_mem_stb} !== {1'b1, 32'h0, 2'b00}) begin
      n_err++; $display("FAIL timeout_term: got %b %h %b%b want 1 00000000 00", o_inst_ack, o_inst_dat, o_mem_cyc, o_mem_stb);
    end
    next_cycle();
    set_inst(0, 0, 0, 0, 0);
    settle();
    n_cmp++; if ({o_bus_timeout, o_grant} !== 3'b100) begin n_err++; $display("FAIL timeout_flag_idle: got %b %b want 1 00", o_bus_timeout, o_grant); end
    next_cycle();
    set_data(1, 1, 0, 32'h600, 0);
    settle();
    next_cycle();
    set_slave(1, 32'h55);
    settle();
    n_cmp++; if ({o_grant, o_data_ack, o_data_dat, o_bus_timeout} !== {2'b10, 1'b1, 32'h55, 1'b1}) begin
      n_err++; $display("FAIL timeout_after_data: got %b %b %h %b want 10 1 00000055 1", o_grant, o_data_ack, o_data_dat, o_bus_timeout);
    end
    next_cycle();
    idle_cycles(2);
  endtask

  task automatic test_mid_reset();
    set_data(1, 1, 0, 32'h700, 0);
    settle();
    next_cycle();
    settle();
    n_cmp++; if (o_grant !== 2'b10) begin n_err++; $display("FAIL midrst_grant: got %b want 10", o_grant); end
    next_cycle();
    rst = 1'b0;
    settle();
    next_cycle();
    rst = 1'b1;
    set_inst(1, 1, 0, 32'h704, 0);
    settle();
    n_cmp++; if ({o_mem_cyc, o_grant, o_bus_timeout, o_data_ack} !== 5'b00000) begin
      n_err++; $display("FAIL midrst_drop: got %b %b %b %b want 0 00 0 0", o_mem_cyc, o_grant, o_bus_timeout, o_data_ack);
    end
    next_cycle();
    settle();
    n_cmp++; if (o_grant !== 2'b10) begin n_err++; $display("FAIL midrst_tie: got %b want 10", o_grant); end
    next_cycle();
    idle_cycles(3);
  endtask

  task automatic test_fairness();
    int         ni = 0;
    int         nd = 0;
    int         diff;
    logic       ic = 1'b1;
    logic       dc = 1'b1;
    logic [1:0] pg = 2'b00;
    for (int n = 0; n < 600 && (ni + nd) < 100; n++) begin
      set_inst(ic, ic, 0, 32'h1000 + n, 0);
      set_data(dc, dc, 0, 32'h8000 + n, 0);
      set_slave((m_owner == 1 && ic) || (m_owner == 2 && dc), $urandom);
      settle();
      v_got = {o_grant, o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat, o_inst_ack, o_inst_dat, o_data_ack, o_data_dat, o_bus_timeout};
      v_exp = {e_grant, e_mem_cyc, e_mem_stb, e_mem_we, e_mem_adr, e_mem_dat, e_inst_ack, e_inst_dat, e_data_ack, e_data_dat, e_timeout};
      n_cmp++; if (v_got !== v_exp) begin n_err++; $display("FAIL fair_outputs cycle %0d: got %h want %h", n, v_got, v_exp); end
      if (o_grant == 2'b01 && pg == 2'b00) ni++;
      if (o_grant == 2'b10 && pg == 2'b00) nd++;
      pg = o_grant;
      ic = ic ? !e_inst_ack : 1'b1;
      dc = dc ? !e_data_ack : 1'b1;
      next_cycle();
    end
    diff = (ni > nd) ? ni - nd : nd - ni;
    n_cmp++; if ((ni + nd) < 100) begin n_err++; $display("FAIL fair_progress: got %0d grants want 100", ni + nd); end
    n_cmp++; if (diff > 1) begin n_err++; $display("FAIL fair_balance: got inst %0d data %0d want difference <= 1", ni, nd); end
    idle_cycles(2);
  endtask

  task automatic test_random();
    logic        ic = 0, iw = 0, dc = 0, dw = 0, own_stb;
    logic [31:0] ia = 0, id = 0, da = 0, dd = 0, want;
    int          igap = 0, dgap = 0, s_lat = 0, prev;
    for (int n = 0; n < 1500; n++) begin
      set_inst(ic, ic, iw, ia, id);
      set_data(dc, dc, dw, da, dd);
      own_stb = (m_owner == 1) ? ic : (m_owner == 2) ? dc : 1'b0;
      set_slave(own_stb && s_lat == 0, $urandom);
      settle();
      v_got = {o_grant, o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat, o_inst_ack, o_inst_dat, o_data_ack, o_data_dat, o_bus_timeout};
      v_exp = {e_grant, e_mem_cyc, e_mem_stb, e_mem_we, e_mem_adr, e_mem_dat, e_inst_ack, e_inst_dat, e_data_ack, e_data_dat, e_timeout};
      n_cmp++; if (v_got !== v_exp) begin n_err++; $display("FAIL rand_outputs cycle %0d: got %h want %h", n, v_got, v_exp); end
      if (e_inst_ack) exp_q.push_back(e_inst_dat);
      if (o_inst_ack === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_inst_read cycle %0d: got ack with %h want no ack", n, o_inst_dat);
        end else begin
          want = exp_q.pop_front();
          if (o_inst_dat !== want) begin n_err++; $display("FAIL rand_inst_read cycle %0d: got %h want %h", n, o_inst_dat, want); end
        end
      end
      if (ic) begin
        if (e_inst_ack) begin ic = 0; igap = $urandom_range(0, 2); end
      end else if (igap > 0) igap--;
      else if ($urandom_range(0, 3) != 0) begin
        ic = 1; iw = 1'($urandom_range(0, 1)); ia = $urandom; id = $urandom;
      end
      if (dc) begin
        if (e_data_ack) begin dc = 0; dgap = $urandom_range(0, 2); end
      end else if (dgap > 0) dgap--;
      else if ($urandom_range(0, 3) != 0) begin
        dc = 1; dw = 1'($urandom_range(0, 1)); da = $urandom; dd = $urandom;
      end
      if (own_stb && !mem_ack && s_lat > 0) s_lat--;
      prev = m_owner;
      next_cycle();
      if (prev == 0 && m_owner != 0) s_lat = $urandom_range(0, 6);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_queue_drain: got %0d pending want 0", exp_q.size()); end
    idle_cycles(2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_tie_from_reset();
    test_write_passthrough();
    test_timeout();
    test_mid_reset();
    test_fairness();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
